booth_mult_seq: RTL and testbench

BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

---
 rtl/booth_mult_seq.sv | 103 ++++++++++
 tb/tb_booth_mult_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned operands.
// One Booth step per clock on (WIDTH+1)-bit operands, result after WIDTH+1 steps.
module booth_mult_seq #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [WIDTH:0]    a;
   logic [WIDTH:0]    q;
   logic [WIDTH-1:0]  m;
   logic              q_m1;
   logic              mode;
   logic [CW-1:0]     cnt;

   logic [WIDTH:0]    m_ext;
   logic [WIDTH:0]    sum;
   logic [WIDTH:0]    a_nxt;
   logic [WIDTH:0]    q_nxt;

   // M is kept at operand width and extended here using the latched mode.
   always_comb begin
      m_ext = {mode & m[WIDTH-1], m};
      case ({q[0], q_m1})
         2'b01:   sum = a + m_ext;
         2'b10:   sum = a - m_ext;
         default: sum = a;
      endcase
      a_nxt = {sum[WIDTH], sum[WIDTH:1]};
      q_nxt = {sum[0], q[WIDTH:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         a       <= '0;
         q       <= '0;
         m       <= '0;
         q_m1    <= 1'b0;
         mode    <= 1'b0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a     <= '0;
                  q     <= {signed_mode & multiplier[WIDTH-1], multiplier};
                  m     <= multiplicand;
                  q_m1  <= 1'b0;
                  mode  <= signed_mode;
                  cnt   <= CW'(WIDTH + 1);
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               a    <= a_nxt;
               q    <= q_nxt;
               q_m1 <= q[0];
               cnt  <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  // Low 2*WIDTH bits of the final {A,Q}.
                  product <= {a_nxt[WIDTH-2:0], q_nxt};
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: driver pushes reference products,
// a negedge monitor pops and compares on every done pulse.
module tb_booth_mult_seq;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           signed_mode = 1'b0;
   logic [W-1:0]   mcand = '0;
   logic [W-1:0]   mplier = '0;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int busy_cycles = 0;
   logic [2*W-1:0] sb[$];
   logic [2*W-1:0] last_exp = '0;

   always #5 clk = ~clk;

   booth_mult_seq #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .signed_mode(signed_mode),
      .multiplicand(mcand),
      .multiplier(mplier),
      .busy(busy),
      .done(done),
      .product(product)
   );

   function automatic logic [2*W-1:0] ref_mul(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y);
      longint px, py, p;
      px = sm ? longint'($signed(x)) : longint'(x);
      py = sm ? longint'($signed(y)) : longint'(y);
      p  = px * py;
      return p[2*W-1:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (busy) busy_cycles++;
      if (!rst && done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=%0h required=none", product);
         end else begin
            last_exp = sb.pop_front();
            check("product", product, last_exp);
            check("busy_in_done", busy, 1'b0);
         end
      end
   end

   // Start is accepted on the next rising edge; operands are scrambled afterwards.
   task automatic issue(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      signed_mode = sm;
      mcand = x;
      mplier = y;
      start = 1'b1;
      sb.push_back(ref_mul(sm, x, y));
      @(negedge clk);
      start = 1'b0;
      signed_mode = 1'($urandom);
      mcand = W'($urandom);
      mplier = W'($urandom);
   endtask

   // Returns negedges counted after issue() returned, up to and including the done cycle.
   task automatic wait_done(output int n);
      logic [2*W-1:0] snap;
      logic moved;
      snap = product;
      moved = 1'b0;
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (done) break;
         if (busy && product !== snap) moved = 1'b1;
         if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=%0d required=<100", n);
            break;
         end
      end
      check("product_hold_calc", moved, 1'b0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return {1'b1, {(W-1){1'b0}}};
         3: return {1'b0, {(W-1){1'b1}}};
         default: return W'($urandom);
      endcase
   endfunction

   typedef struct { logic sm; logic [W-1:0] x; logic [W-1:0] y; } vec_t;
   vec_t dirv[$];

   initial begin
      int n;
      int dc0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_product", product, '0);
      rst = 1'b0;

      busy_cycles = 0;
      issue(1'b1, 16'hFFFB, 16'h0003);
      wait_done(n);
      check("latency", n + 1, 18);
      check("busy_cycles", busy_cycles, 17);
      check("neg5x3", product, 32'hFFFFFFF1);

      dirv.push_back('{1'b0, 16'hFFFF, 16'hFFFF});
      dirv.push_back('{1'b1, 16'hFFFF, 16'hFFFF});
      dirv.push_back('{1'b1, 16'h8000, 16'h8000});
      dirv.push_back('{1'b1, 16'h7FFF, 16'h8000});
      dirv.push_back('{1'b1, 16'h0000, 16'h1234});
      dirv.push_back('{1'b0, 16'h1234, 16'h0000});
      foreach (dirv[i]) begin
         issue(dirv[i].sm, dirv[i].x, dirv[i].y);
         wait_done(n);
         check("latency_dir", n + 1, 18);
      end
      check("ff_u", ref_mul(1'b0, 16'hFFFF, 16'hFFFF), 32'hFFFE0001);
      repeat (2) @(negedge clk);
      check("idle_hold", product, last_exp);
      check("idle_done", done, 1'b0);

      dc0 = done_cnt;
      issue(1'b0, 16'h1234, 16'h5678);
      repeat (4) @(negedge clk);
      signed_mode = 1'b1;
      mcand = 16'hFFFF;
      mplier = 16'hFFFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      repeat (5) @(negedge clk);
      check("busy_start_product", product, 32'h1234 * 32'h5678);
      check("busy_start_one_done", done_cnt - dc0, 1);
      check("busy_start_idle", busy, 1'b0);

      issue(1'b1, 16'h4321, 16'h8765);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_product", product, '0);
      sb.delete();
      dc0 = done_cnt;
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      check("midrst_no_done", done_cnt - dc0, 0);
      check("midrst_hold", product, '0);
      issue(1'b1, 16'hFFFB, 16'h0003);
      wait_done(n);
      check("midrst_latency", n + 1, 18);

      for (int unsigned i = 0; i < 3000; i++) begin
         issue(1'($urandom), pick(), pick());
         wait_done(n);
      end
      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
